// File: rtl/spectrum_framer_pkg.sv
// Shared types for the spectrum framer: header bytes, tx state enum, FIFO entry.
// SPECTRUM_FRAMER_CHECKSUM_EN adds the CSUM state to the enum.
package spectrum_framer_pkg;

  localparam logic [7:0] HDR0_BYTE = 8'hA5;
  localparam logic [7:0] HDR1_BYTE = 8'h5A;
  localparam int         MAG_W     = 24;

`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_B2, ST_B1, ST_B0, ST_CSUM
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR0, ST_HDR1, ST_B2, ST_B1, ST_B0
  } tx_state_t;
`endif

  typedef struct packed {
    logic             sof;
    logic [MAG_W-1:0] mag;
  } fifo_entry_t;

endpackage

// File: rtl/spectrum_framer_sync_fifo.sv
// Show-ahead synchronous FIFO with free-space count; head_dat is valid whenever !empty.
// One-cycle write-to-read latency; a push into a full FIFO is only taken alongside a pop.
module sync_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 64
) (
  input  logic                     sys_clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign head_dat = mem[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign free_cnt = (AW+1)'(DEPTH) - count;

  always_ff @(posedge sys_clock) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spectrum_framer.sv
// Squares FFT bins (2-cycle pipeline), buffers whole frames, serialises A5 5A + 3 bytes/bin over valid/ready.
// Frames without room at sync are dropped (sticky o_overflow); SPECTRUM_FRAMER_CHECKSUM_EN appends an XOR byte.
module spectrum_framer
  import spectrum_framer_pkg::*;
#(
  parameter int FFT_LEN    = 64,
  parameter int BIN_W      = 11,
  parameter int FIFO_DEPTH = 64
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  input  logic               i_ce,
  input  logic               i_sync,
  input  logic [2*BIN_W-1:0] i_data,
  output logic [7:0]         o_byte,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_overflow
);

  localparam int HALF = FFT_LEN / 2;
  localparam int CW   = $clog2(HALF) + 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  logic signed [2*BIN_W-1:0] re_x, im_x;
  logic [2*BIN_W-1:0] sq_re, sq_im;
  logic [MAG_W-1:0]   s2_mag;
  logic               s1_vld, s1_sof, s2_vld, s2_sof;
  logic [CW-1:0]      bin_cnt, bin_idx, sent;
  logic               synced, admit, sync_ok, take;
  logic [AW:0]        free_cnt, room;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop, xfer;
  fifo_entry_t        push_ent, head;
  logic [$bits(fifo_entry_t)-1:0] head_dat;
  tx_state_t          state;
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign re_x = {{BIN_W{i_data[2*BIN_W-1]}}, i_data[2*BIN_W-1:BIN_W]};
  assign im_x = {{BIN_W{i_data[BIN_W-1]}}, i_data[BIN_W-1:0]};

  // Entries still in the pipeline already own FIFO slots.
  assign room    = free_cnt - {{AW{1'b0}}, s1_vld} - {{AW{1'b0}}, s2_vld};
  assign sync_ok = (room >= (AW+1)'(HALF));
  assign bin_idx = i_sync ? '0 : bin_cnt;
  assign take    = i_ce && (i_sync ? sync_ok : (synced && admit)) && (bin_idx < CW'(HALF));

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt    <= '0;
      synced     <= 1'b0;
      admit      <= 1'b0;
      o_overflow <= 1'b0;
      s1_vld     <= 1'b0;
      s1_sof     <= 1'b0;
      s2_vld     <= 1'b0;
      s2_sof     <= 1'b0;
      sq_re      <= '0;
      sq_im      <= '0;
      s2_mag     <= '0;
    end else begin
      if (i_ce) begin
        if (i_sync) begin
          synced  <= 1'b1;
          admit   <= sync_ok;
          bin_cnt <= CW'(1);
          if (!sync_ok) o_overflow <= 1'b1;
        end else if (bin_cnt < CW'(HALF)) begin
          bin_cnt <= bin_cnt + 1'b1;
        end
      end
      s1_vld <= take;
      s1_sof <= take && i_sync;
      if (take) begin
        sq_re <= re_x * re_x;
        sq_im <= im_x * im_x;
      end
      s2_vld <= s1_vld;
      s2_sof <= s1_sof;
      s2_mag <= MAG_W'(sq_re) + MAG_W'(sq_im);
    end
  end

  assign push_ent.sof = s2_sof;
  assign push_ent.mag = s2_mag;
  assign fifo_push    = s2_vld && (!fifo_full || fifo_pop);
  assign head         = head_dat;

  sync_fifo #(
    .W     ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_dat  (push_ent),
    .pop       (fifo_pop),
    .head_dat  (head_dat),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .free_cnt  (free_cnt)
  );

  // Stray non-sof heads in IDLE are flushed; otherwise an entry leaves on its B0 byte.
  always_comb begin
    xfer     = o_valid && i_ready;
    fifo_pop = 1'b0;
    if (state == ST_IDLE && !fifo_empty && !head.sof) fifo_pop = 1'b1;
    if (state == ST_B0 && xfer)                       fifo_pop = 1'b1;
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
      o_byte  <= '0;
      sent    <= '0;
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty && head.sof) begin
          state   <= ST_HDR0;
          o_valid <= 1'b1;
          o_byte  <= HDR0_BYTE;
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
          csum    <= '0;
`endif
        end
        ST_HDR0: if (xfer) begin
          state  <= ST_HDR1;
          o_byte <= HDR1_BYTE;
        end
        ST_HDR1: if (xfer) begin
          state  <= ST_B2;
          o_byte <= head.mag[23:16];
          sent   <= '0;
        end
        // B2 with o_valid low waits for the next entry; a sof head there is an early sync.
        ST_B2: if (o_valid) begin
          if (xfer) begin
            state  <= ST_B1;
            o_byte <= head.mag[15:8];
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
            csum   <= csum ^ o_byte;
`endif
          end
        end else if (!fifo_empty) begin
          if (head.sof) begin
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
            state   <= ST_CSUM;
            o_valid <= 1'b1;
            o_byte  <= csum;
`else
            state   <= ST_IDLE;
`endif
          end else begin
            o_valid <= 1'b1;
            o_byte  <= head.mag[23:16];
          end
        end
        ST_B1: if (xfer) begin
          state  <= ST_B0;
          o_byte <= head.mag[7:0];
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
          csum   <= csum ^ o_byte;
`endif
        end
        ST_B0: if (xfer) begin
          sent <= sent + 1'b1;
          if ((sent + 1'b1) == CW'(HALF)) begin
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
            state  <= ST_CSUM;
            o_byte <= csum ^ o_byte;
`else
            state   <= ST_IDLE;
            o_valid <= 1'b0;
`endif
          end else begin
            state   <= ST_B2;
            o_valid <= 1'b0;
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
            csum    <= csum ^ o_byte;
`endif
          end
        end
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
        ST_CSUM: if (xfer) begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
`endif
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_framer.sv
// Directed bench for spectrum_framer (FFT_LEN=8, FIFO_DEPTH=8); checksum byte expected
// only when SPECTRUM_FRAMER_CHECKSUM_EN is defined for the build.
module tb_spectrum_framer;

  localparam int FFT_LEN    = 8;
  localparam int BIN_W      = 11;
  localparam int FIFO_DEPTH = 8;
  localparam int HALF       = FFT_LEN / 2;

  logic               sys_clock = 1'b0;
  logic               reset_n   = 1'b0;
  logic               i_ce      = 1'b0;
  logic               i_sync    = 1'b0;
  logic               i_ready   = 1'b0;
  logic [2*BIN_W-1:0] i_data    = '0;
  logic [7:0]         o_byte;
  logic               o_valid;
  logic               o_overflow;

  spectrum_framer #(
    .FFT_LEN    (FFT_LEN),
    .BIN_W      (BIN_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .i_ce       (i_ce),
    .i_sync     (i_sync),
    .i_data     (i_data),
    .o_byte     (o_byte),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_overflow (o_overflow)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct {
    logic signed [BIN_W-1:0] re;
    logic signed [BIN_W-1:0] im;
    logic [23:0]             mag;
  } vec_t;

  vec_t       tbl [12];
  vec_t       fr  [HALF];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int         checks   = 0;
  int         failures = 0;
  logic       last_valid = 1'b0;
  logic       last_ovf   = 1'b0;
  logic       saw_valid  = 1'b0;
  logic [7:0] last_byte  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Observe at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge sys_clock);
    last_valid = o_valid;
    last_byte  = o_byte;
    last_ovf   = o_overflow;
    if (o_valid) saw_valid = 1'b1;
    if (o_valid && i_ready) rx_q.push_back(o_byte);
    @(posedge sys_clock);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sample(input logic sync, input logic signed [BIN_W-1:0] re,
                        input logic signed [BIN_W-1:0] im);
    i_ce   = 1'b1;
    i_sync = sync;
    i_data = {re, im};
    tick();
    i_ce   = 1'b0;
    i_sync = 1'b0;
    i_data = '0;
  endtask

  // Full frames also carry bins HALF..FFT_LEN-1 with a loud value that must be ignored.
  task automatic send_frame(input int nbins);
    for (int b = 0; b < nbins; b++) sample(b == 0, fr[b].re, fr[b].im);
    if (nbins == HALF)
      for (int b = HALF; b < FFT_LEN; b++) sample(1'b0, -11'sd1024, -11'sd1024);
  endtask

  task automatic expect_frame(input int nbins);
    logic [7:0] cs;
    logic [23:0] m;
    cs = '0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int b = 0; b < nbins; b++) begin
      m = fr[b].mag;
      exp_q.push_back(m[23:16]);
      exp_q.push_back(m[15:8]);
      exp_q.push_back(m[7:0]);
      cs = cs ^ m[23:16] ^ m[15:8] ^ m[7:0];
    end
`ifdef SPECTRUM_FRAMER_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic fill(input logic signed [BIN_W-1:0] re, input logic signed [BIN_W-1:0] im,
                      input logic [23:0] mag);
    for (int b = 0; b < HALF; b++) fr[b] = '{re, im, mag};
  endtask

  task automatic compare_stream(input string name);
    chk($sformatf("%s length", name), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s byte%0d", name, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tbl[0]  = '{11'sd3,     11'sd4,     24'h000019};
    tbl[1]  = '{11'sd3,     11'sd4,     24'h000019};
    tbl[2]  = '{11'sd3,     11'sd4,     24'h000019};
    tbl[3]  = '{11'sd3,     11'sd4,     24'h000019};
    tbl[4]  = '{11'sd1023,  11'sd1023,  24'h1FF002};
    tbl[5]  = '{-11'sd1,    11'sd0,     24'h000001};
    tbl[6]  = '{11'sd0,     11'sd0,     24'h000000};
    tbl[7]  = '{11'sd100,   -11'sd200,  24'h00C350};
    tbl[8]  = '{-11'sd1024, 11'sd0,     24'h100000};
    tbl[9]  = '{-11'sd7,    11'sd12,    24'h0000C1};
    tbl[10] = '{-11'sd1024, -11'sd1024, 24'h200000};
    tbl[11] = '{11'sd3,     11'sd4,     24'h000019};

    // Reset values
    run(3);
    chk("reset o_valid", last_valid, 1'b0);
    chk("reset o_byte", last_byte, 8'h00);
    chk("reset o_overflow", last_ovf, 1'b0);
    reset_n = 1'b1;
    i_ready = 1'b1;
    run(2);

    // Samples before the first sync are ignored
    for (int i = 0; i < 3; i++) sample(1'b0, 11'sd3, 11'sd4);
    run(10);
    chk("presync bytes", rx_q.size(), 0);

    // Table-driven frames
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < HALF; b++) fr[b] = tbl[4*f+b];
      send_frame(HALF);
      expect_frame(HALF);
      run(40);
    end
    compare_stream("table");

    // Backpressure held during B1
    i_ready = 1'b0;
    fill(11'sd100, -11'sd200, 24'h00C350);
    send_frame(HALF);
    expect_frame(HALF);
    i_ready = 1'b1;
    for (int i = 0; i < 50 && rx_q.size() < 3; i++) tick();
    chk("bp reach B1", rx_q.size(), 3);
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp hold valid c%0d", i), last_valid, 1'b1);
      chk($sformatf("bp hold byte c%0d", i), last_byte, 8'hC3);
    end
    i_ready = 1'b1;
    run(40);
    compare_stream("bp");

    // Early syncs: 1-bin frame, 2-bin frame, then a full frame
    fr[0] = '{-11'sd1024, -11'sd1024, 24'h200000};
    send_frame(1);
    expect_frame(1);
    fr[0] = '{-11'sd7, 11'sd12, 24'h0000C1};
    fr[1] = '{-11'sd1, 11'sd0,  24'h000001};
    send_frame(2);
    expect_frame(2);
    fill(11'sd3, 11'sd4, 24'h000019);
    send_frame(HALF);
    expect_frame(HALF);
    run(100);
    compare_stream("early");

    // Overflow: third frame has no room while the sink stalls
    i_ready = 1'b0;
    run(2);
    chk("ovf before", last_ovf, 1'b0);
    fill(11'sd3, 11'sd4, 24'h000019);
    send_frame(HALF);
    expect_frame(HALF);
    fill(-11'sd1, 11'sd0, 24'h000001);
    send_frame(HALF);
    expect_frame(HALF);
    fill(11'sd0, 11'sd0, 24'h000000);
    send_frame(HALF);
    run(3);
    chk("ovf set", last_ovf, 1'b1);
    i_ready = 1'b1;
    run(150);
    compare_stream("ovf");
    chk("ovf sticky", last_ovf, 1'b1);

    // Reset while in B2, then unsynced bins must produce nothing
    i_ready = 1'b0;
    fill(-11'sd1024, -11'sd1024, 24'h200000);
    send_frame(HALF);
    i_ready = 1'b1;
    for (int i = 0; i < 20 && rx_q.size() < 2; i++) tick();
    chk("rst reach B2", rx_q.size(), 2);
    i_ready = 1'b0;
    tick();
    chk("rst B2 byte", last_byte, 8'h20);
    reset_n = 1'b0;
    tick();
    chk("rst o_valid", last_valid, 1'b0);
    chk("rst o_byte", last_byte, 8'h00);
    chk("rst o_overflow", last_ovf, 1'b0);
    reset_n = 1'b1;
    rx_q.delete();
    saw_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < FFT_LEN; i++) sample(1'b0, 11'sd3, 11'sd4);
    run(30);
    chk("rst no bytes", rx_q.size(), 0);
    chk("rst no valid", saw_valid, 1'b0);
    fill(11'sd3, 11'sd4, 24'h000019);
    send_frame(HALF);
    expect_frame(HALF);
    run(40);
    compare_stream("post rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
